// File: rtl/call_stack.sv
// Hardware call/return stack holding {return PC, ALU flags} pairs.
// Push stores a frame, pop returns the top frame through registered outputs
// one cycle later, push+pop together swaps the top frame.
// Overflow and underflow are sticky until cleared.
module call_stack #(
    parameter int DEPTH   = 5,
    parameter int PC_W    = 8,
    parameter int FLAGS_W = 4
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_push,
    input  logic               in_pop,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [FLAGS_W-1:0] in_flags,
    input  logic               in_clear_err,
    output logic [PC_W-1:0]    out_pc,
    output logic [FLAGS_W-1:0] out_flags,
    output logic               out_pop_valid,
    output logic [2:0]         out_depth,
    output logic               out_empty,
    output logic               out_full,
    output logic               out_overflow,
    output logic               out_underflow
);

    localparam int         ENTRY_W = PC_W + FLAGS_W;
    localparam logic [2:0] DEPTH_V = 3'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [2:0]         sp;
    logic [2:0]         top_idx;

    logic do_pop;
    logic do_swap;
    logic do_push_only;
    logic overflow_evt;
    logic underflow_evt;

    // Classify the request against the current pointer.  A push+pop on an
    // empty stack degenerates into a plain push (plus underflow).
    always_comb begin
        top_idx       = sp - 3'd1;
        do_pop        = in_pop && (sp != 3'd0);
        do_swap       = in_push && in_pop && (sp != 3'd0);
        do_push_only  = in_push && (!in_pop || (sp == 3'd0)) && (sp != DEPTH_V);
        overflow_evt  = in_push && !in_pop && (sp == DEPTH_V);
        underflow_evt = in_pop && (sp == 3'd0);
    end

    // Frame storage; not reset because entries at or above sp are never read.
    always_ff @(posedge in_clk) begin
        if (do_push_only) begin
            mem[sp] <= {in_pc, in_flags};
        end else if (do_swap) begin
            mem[top_idx] <= {in_pc, in_flags};
        end
    end

    // Stack pointer, registered pop result and sticky error flags.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sp            <= 3'd0;
            out_pc        <= '0;
            out_flags     <= '0;
            out_pop_valid <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            out_pop_valid <= do_pop;
            if (do_pop) begin
                {out_pc, out_flags} <= mem[top_idx];
            end
            if (do_push_only) begin
                sp <= sp + 3'd1;
            end else if (do_pop && !do_swap) begin
                sp <= sp - 3'd1;
            end
            // An error in the same cycle as a clear wins over the clear.
            out_overflow  <= overflow_evt  || (out_overflow  && !in_clear_err);
            out_underflow <= underflow_evt || (out_underflow && !in_clear_err);
        end
    end

    // Status decoded straight from sp so it tracks the pointer without delay.
    always_comb begin
        out_depth = sp;
        out_empty = (sp == 3'd0);
        out_full  = (sp == DEPTH_V);
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: in_clk is the single clock; in_rst_n is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 5, SHALL set the number of stack entries.
REQ-003 Parameter PC_W, default 8, SHALL set the return-address width.
REQ-004 Parameter FLAGS_W, default 4, SHALL set the ALU flag width.
REQ-005 in_clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-006 in_rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-007 in_push  input  1  SHALL request a push of {in_pc, in_flags} (call).
REQ-008 in_pop  input  1  SHALL request a pop of the top entry (ret).
REQ-009 in_pc  input  PC_W  SHALL carry the return PC to push.
REQ-010 in_flags  input  FLAGS_W  SHALL carry the flags to push.
REQ-011 in_clear_err  input  1  SHALL clear the sticky error flags.
REQ-012 out_pc  output  PC_W  SHALL carry the registered PC from the last pop.
REQ-013 out_flags  output  FLAGS_W  SHALL carry the registered flags from the last pop.
REQ-014 out_pop_valid  output  1  SHALL pulse for one cycle after a successful pop.
REQ-015 out_depth  output  3  SHALL give the current entry count, 0..DEPTH.
REQ-016 out_empty / out_full  output  1 each  SHALL be high when depth==0 / depth==DEPTH.
REQ-017 out_overflow / out_underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-018 Storage SHALL be DEPTH entries of {PC, flags} with a stack pointer sp (0..DEPTH); out_depth SHALL equal sp.
REQ-019 Push only (no pop), sp<DEPTH: entry[sp] <= {in_pc,in_flags}, sp <= sp+1 at the same edge.
REQ-020 Pop only (no push), sp>0: {out_pc,out_flags} <= entry[sp-1], sp <= sp-1, and out_pop_valid SHALL be 1 in the following cycle (1-cycle latency).
REQ-021 Push with sp==DEPTH SHALL be ignored (storage and sp unchanged) and SHALL set out_overflow.
REQ-022 Pop with sp==0 SHALL be ignored (out_pc/out_flags held, out_pop_valid 0) and SHALL set out_underflow.
REQ-023 Push and pop together with sp>0 SHALL return entry[sp-1] as a pop (out_pop_valid pulses), write the new value into entry[sp-1], and leave sp unchanged.
REQ-024 Push and pop together with sp==0 SHALL act as push only and SHALL set out_underflow.
REQ-025 out_pc/out_flags SHALL hold their value between pops.
REQ-026 out_empty, out_full and out_depth SHALL be decoded from sp and valid in the same cycle sp changes.
REQ-027 in_clear_err SHALL clear both sticky flags; if an error event occurs in the same cycle, the error flag SHALL end the cycle set.
REQ-028 Entries above sp SHALL be don't-care and SHALL NOT be observable on any output.

Reset
REQ-029 On in_rst_n low, immediately and independently of in_clk: sp=0, out_pc=0, out_flags=0, out_pop_valid=0, out_overflow=0, out_underflow=0, out_empty=1, out_full=0, out_depth=0.
REQ-030 Entry storage need not be reset.
REQ-031 Reset asserted mid-push or mid-pop SHALL discard the operation.
REQ-032 The first edge after deassertion SHALL process requests normally.

Verification
REQ-033 Push PC 0x11..0x15 (flags 0x1..0x5) in 5 cycles, then pop 5 times -> out_pc 0x15,0x14,0x13,0x12,0x11 with matching flags, out_pop_valid high each following cycle, out_full=1 after 5th push, out_empty=1 at end.
REQ-034 Fill to 5 entries, push 0x99 -> depth stays 5, out_overflow=1, next pop returns 0x15 (not 0x99).
REQ-035 Pop from reset -> out_underflow=1, out_pop_valid=0, out_pc=0; pulse in_clear_err -> out_underflow=0.
REQ-036 Depth 2 (top 0x22), push 0x77 with pop -> out_pc=0x22, depth stays 2, next pop returns 0x77.
REQ-037 Depth 3, assert in_rst_n low between edges -> outputs return to reset values immediately, with no clock edge required.
REQ-038 Overflow event with in_clear_err high in the same cycle -> out_overflow=1 afterwards.
